srrc_tx_polyphase_flt: RTL and testbench
========================================

// Module: srrc_tx_polyphase_flt
// PURPOSE
//  Transmit-side SRRC pulse-shaping filter: the counterpart of the matched RX filter. Takes one
//  18-bit 1s17 symbol level per symbol period and produces SPS shaped samples per symbol.
//  Polyphase form: no zero-stuffing, one coefficient phase per output sample.
//  Sits between the symbol mapper and the DAC/channel model.
// PARAMETERS
//  SPS     4    samples per symbol; phase counter modulus (power of 2)
//  NSYM    25   symbol delay-line depth (taps per phase)
//  NTAPS   100  total coefficients = SPS*NSYM; coef[0..NTAPS-1] from srrc_tx_coefs.vh, 18-bit 1s17
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-low reset
//  sam_clk_en  in   1   sample strobe, one clk wide; pulses at least 3 clk apart
//  sym_clk_en  in   1   symbol strobe; legal only coincident with sam_clk_en
//  in          in   18  signed 1s17 symbol level, sampled when sym_clk_en=1
//  out         out  18  signed 1s17 shaped sample, updated only on sam_clk_en
//  phase       out  2   current polyphase index (debug)
//  sym_err     out  1   sticky framing-error flag
// BEHAVIOUR
//  Reset (reset=0, async): sym[0..NSYM-1]=0, phase=0, product regs=0, out=0, sym_err=0.
//  Symbol line, on clk edge with sam_clk_en=1 && sym_clk_en=1: sym[0]<=in, sym[k]<=sym[k-1],
//   phase<=0.
//  Phase, on sam_clk_en=1 && sym_clk_en=0: phase<=(phase+1) mod SPS.
//   From SPS-1 it wraps to 0 WITHOUT shifting (line repeats); sym_err<=1.
//  sym_clk_en=1 with sam_clk_en=0: ignored (no shift, no phase change); sym_err<=1.
//  sym_err clears only on reset.
//  Products, every clk (not enabled): p[k] <= sym[k]*coef[phase+SPS*k], k=0..NSYM-1.
//   Full 36-bit product; keep bits [34:17] (1s17).
//  Sum: combinational tree over p[k] at 18+ceil(log2(NSYM)) bits = 23 bits, no intermediate wrap.
//  Output: on sam_clk_en, out <= sat18(sum).
//   Saturation: >0x1FFFF -> 0x1FFFF; <-0x20000 -> 0x20000.
//  Latency: the out value loaded at sam_clk_en pulse n reflects sym/phase as set at pulse n-1
//   (one sample period). Products settle 1 clk after state change, so 3-clk strobe spacing
//   guarantees correctness.
//  Stalls: sam_clk_en low => out, phase, sym line all hold.
//  Reset mid-stream: everything clears immediately. Output restarts from zero history: the first
//   sam_clk_en after release loads 0.
//  Coefficient order: sample j after a symbol enters sym[0] (phase j) uses coef[j];
//   after that symbol moves to sym[k], it contributes coef[SPS*k+phase].
// TESTING
//  1 Impulse: one symbol 0x10000 (0.5) then zeros, SPS-aligned strobes
//    -> out sequence from the 2nd sam_clk_en = coef[0..99]>>1 (bit-exact, trunc), then 0.
//  2 DC: constant symbol 0x08000 for >NSYM symbols
//    -> out steady per phase p = sat(sum_k trunc(0x08000*coef[p+4k])); repeats every 4 samples.
//  3 Saturation: alternate sign of symbols to match sign(coef[SPS*k]) at 0x1FFFF
//    -> out clamps to 0x1FFFF on phase 0, never wraps negative.
//  4 Stall: hold sam_clk_en low 40 clk mid-stream -> out/phase unchanged; resumes identical to
//    unstalled golden sequence.
//  5 Framing: 5 sam_clk_en with no sym_clk_en -> phase 0,1,2,3,0, sym_err=1 on 4th;
//    sym_clk_en alone -> ignored, sym_err=1.
//  6 Reset mid-stream (low 2 clk, async to edge) -> out=0, phase=0, sym_err=0 at once;
//    post-release impulse test reproduces case 1.

Source files
------------

// File: rtl/srrc_tx_polyphase_flt.sv
// Transmit SRRC pulse shaper in polyphase form: one symbol in per symbol period, SPS shaped
// samples out, one coefficient phase per output sample.
module srrc_tx_polyphase_flt #(
    parameter int unsigned SPS   = 4,
    parameter int unsigned NSYM  = 25,
    parameter int unsigned NTAPS = SPS * NSYM,
    parameter logic signed [17:0] COEF [NTAPS] = '{
        18'sd20, -18'sd101, -18'sd104, 18'sd29, 18'sd140, 18'sd86, -18'sd77, -18'sd148,
        -18'sd28, 18'sd146, 18'sd150, -18'sd43, -18'sd207, -18'sd130, 18'sd113, 18'sd223,
        18'sd41, -18'sd227, -18'sd235, 18'sd71, 18'sd340, 18'sd219, -18'sd183, -18'sd373,
        -18'sd67, 18'sd403, 18'sd422, -18'sd138, -18'sd655, -18'sd444, 18'sd343, 18'sd747,
        18'sd124, -18'sd904, -18'sd968, 18'sd374, 18'sd1757, 18'sd1328, -18'sd852, -18'sd2196,
        -18'sd257, 18'sd3647, 18'sd4232, -18'sd2715, -18'sd13868, -18'sd17310, -18'sd168,
        18'sd39796, 18'sd88463, 18'sd121943, 18'sd121943, 18'sd88463, 18'sd39796, -18'sd168,
        -18'sd17310, -18'sd13868, -18'sd2715, 18'sd4232, 18'sd3647, -18'sd257, -18'sd2196,
        -18'sd852, 18'sd1328, 18'sd1757, 18'sd374, -18'sd968, -18'sd904, 18'sd124, 18'sd747,
        18'sd343, -18'sd444, -18'sd655, -18'sd138, 18'sd422, 18'sd403, -18'sd67, -18'sd373,
        -18'sd183, 18'sd219, 18'sd340, 18'sd71, -18'sd235, -18'sd227, 18'sd41, 18'sd223,
        18'sd113, -18'sd130, -18'sd207, -18'sd43, 18'sd150, 18'sd146, -18'sd28, -18'sd148,
        -18'sd77, 18'sd86, 18'sd140, 18'sd29, -18'sd104, -18'sd101, 18'sd20
    }
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sam_clk_en,
    input  logic                   sym_clk_en,
    input  logic [17:0]            in,
    output logic [17:0]            out,
    output logic [$clog2(SPS)-1:0] phase,
    output logic                   sym_err
);
    localparam int unsigned PW = $clog2(SPS);
    localparam int unsigned IW = $clog2(NTAPS);
    localparam int unsigned SW = 18 + $clog2(NSYM);
    localparam logic signed [SW-1:0] SAT_MAX = SW'(131071);
    localparam logic signed [SW-1:0] SAT_MIN = -SW'(131072);

    logic signed [17:0]   sym_q  [NSYM];
    logic signed [17:0]   prod_q [NSYM];
    logic [PW-1:0]        phase_q;
    logic [17:0]          out_q;
    logic                 sym_err_q;
    logic signed [SW-1:0] sum;
    logic [17:0]          sat;

    // Symbol delay line, phase counter and sticky framing flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSYM; k++) begin
                sym_q[k] <= '0;
            end
            phase_q   <= '0;
            sym_err_q <= 1'b0;
        end else if (sam_clk_en && sym_clk_en) begin
            sym_q[0] <= in;
            for (int k = 1; k < NSYM; k++) begin
                sym_q[k] <= sym_q[k-1];
            end
            phase_q <= '0;
        end else if (sam_clk_en) begin
            // Missing symbol strobe: phase wraps and the line repeats unshifted.
            phase_q <= phase_q + PW'(1);
            if (phase_q == PW'(SPS - 1)) begin
                sym_err_q <= 1'b1;
            end
        end else if (sym_clk_en) begin
            sym_err_q <= 1'b1;
        end
    end

    // Products track the current phase every clk; only the output waits for the sample strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSYM; k++) begin
                prod_q[k] <= '0;
            end
            out_q <= '0;
        end else begin
            for (int k = 0; k < NSYM; k++) begin
                prod_q[k] <= 18'((36'(sym_q[k]) * 36'(COEF[IW'(SPS * k) + IW'(phase_q)])) >>> 17);
            end
            if (sam_clk_en) begin
                out_q <= sat;
            end
        end
    end

    // Sum is wide enough for NSYM full-scale terms, so only the final result is clamped.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NSYM; k++) begin
            sum = sum + SW'(prod_q[k]);
        end
        if (sum > SAT_MAX) begin
            sat = 18'h1FFFF;
        end else if (sum < SAT_MIN) begin
            sat = 18'h20000;
        end else begin
            sat = sum[17:0];
        end
    end

    assign out     = out_q;
    assign phase   = phase_q;
    assign sym_err = sym_err_q;

endmodule

// File: tb/tb_srrc_tx_polyphase_flt.sv
// Directed bench for srrc_tx_polyphase_flt: a behavioural model pushes expected samples to a
// queue as strobes are driven; each is popped and compared once the DUT loads its output.
module tb_srrc_tx_polyphase_flt;
    localparam int SPS   = 4;
    localparam int NSYM  = 25;
    localparam int NTAPS = 100;
    localparam int COEF [NTAPS] = '{
        20, -101, -104, 29, 140, 86, -77, -148, -28, 146,
        150, -43, -207, -130, 113, 223, 41, -227, -235, 71,
        340, 219, -183, -373, -67, 403, 422, -138, -655, -444,
        343, 747, 124, -904, -968, 374, 1757, 1328, -852, -2196,
        -257, 3647, 4232, -2715, -13868, -17310, -168, 39796, 88463, 121943,
        121943, 88463, 39796, -168, -17310, -13868, -2715, 4232, 3647, -257,
        -2196, -852, 1328, 1757, 374, -968, -904, 124, 747, 343,
        -444, -655, -138, 422, 403, -67, -373, -183, 219, 340,
        71, -235, -227, 41, 223, 113, -130, -207, -43, 150,
        146, -28, -148, -77, 86, 140, 29, -104, -101, 20
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sam_clk_en = 1'b0;
    logic        sym_clk_en = 1'b0;
    logic [17:0] in_s = '0;
    logic [17:0] out_s;
    logic [1:0]  phase_s;
    logic        sym_err_s;

    always #5 clk = ~clk;

    srrc_tx_polyphase_flt dut (
        .clk        (clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .in         (in_s),
        .out        (out_s),
        .phase      (phase_s),
        .sym_err    (sym_err_s)
    );

    int          checks = 0;
    int          errors = 0;
    int          m_sym [NSYM];
    int          m_phase;
    bit          m_err;
    logic [17:0] exp_q [$];
    logic [17:0] last_exp;

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NSYM; k++) m_sym[k] = 0;
        m_phase = 0;
        m_err   = 1'b0;
    endtask

    function automatic logic [17:0] model_out();
        longint            acc;
        longint            pr;
        logic signed [17:0] p18;
        acc = 0;
        for (int k = 0; k < NSYM; k++) begin
            pr  = longint'(m_sym[k]) * longint'(COEF[SPS * k + m_phase]);
            p18 = 18'(pr >>> 17);
            acc += longint'(p18);
        end
        if (acc > 131071) return 18'h1FFFF;
        if (acc < -131072) return 18'h20000;
        return 18'(acc);
    endfunction

    task automatic model_step(input bit sam, input bit sym, input logic [17:0] din);
        if (sam && sym) begin
            for (int k = NSYM - 1; k > 0; k--) m_sym[k] = m_sym[k-1];
            m_sym[0] = int'($signed(din));
            m_phase  = 0;
        end else if (sam) begin
            if (m_phase == SPS - 1) m_err = 1'b1;
            m_phase = (m_phase + 1) % SPS;
        end else if (sym) begin
            m_err = 1'b1;
        end
    endtask

    // One sample strobe (optionally with a symbol), then two idle clocks.
    task automatic pulse(input bit sym, input logic [17:0] din);
        exp_q.push_back(model_out());
        sam_clk_en = 1'b1;
        sym_clk_en = sym;
        in_s       = din;
        tick();
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        model_step(1'b1, sym, din);
        last_exp = exp_q.pop_front();
        check("out", out_s, last_exp);
        check("phase", 18'(phase_s), 18'(m_phase));
        check("sym_err", 18'(sym_err_s), 18'(m_err));
        tick();
        tick();
    endtask

    task automatic run_symbols(input int n, input logic [17:0] level);
        for (int s = 0; s < n; s++) begin
            pulse(1'b1, level);
            for (int j = 1; j < SPS; j++) pulse(1'b0, 18'h0);
        end
    endtask

    task automatic run_impulse(input string tag);
        bit sym;
        for (int i = 0; i < 108; i++) begin
            sym = (i % SPS == 0);
            pulse(sym, (i == 0) ? 18'h10000 : 18'h0);
            if (i >= 1 && i <= NTAPS) check(tag, out_s, 18'(COEF[i-1] >>> 1));
            else if (i > NTAPS) check({tag, "_tail"}, out_s, 18'h0);
        end
    endtask

    initial begin
        logic [17:0] sat_sym;
        logic [1:0]  held_phase;
        model_reset();

        // Reset state
        #2;
        check("rst_out", out_s, 18'h0);
        check("rst_phase", 18'(phase_s), 18'h0);
        check("rst_err", 18'(sym_err_s), 18'h0);
        #20 reset = 1'b1;
        tick();

        // Impulse response
        run_impulse("impulse");

        // DC with a 40-clk stall in the middle
        run_symbols(15, 18'h08000);
        pulse(1'b1, 18'h08000);
        pulse(1'b0, 18'h0);
        held_phase = phase_s;
        repeat (40) tick();
        check("stall_out", out_s, last_exp);
        check("stall_phase", 18'(phase_s), 18'(m_phase));
        check("stall_phase_held", 18'(phase_s), 18'(held_phase));
        pulse(1'b0, 18'h0);
        pulse(1'b0, 18'h0);
        run_symbols(15, 18'h08000);

        // Saturation: full-scale symbols signed to match the phase-0 taps
        for (int i = 0; i < NSYM; i++) begin
            sat_sym = (COEF[SPS * (NSYM - 1 - i)] >= 0) ? 18'h1FFFF : 18'h20001;
            pulse(1'b1, sat_sym);
            if (i < NSYM - 1) for (int j = 1; j < SPS; j++) pulse(1'b0, 18'h0);
        end
        pulse(1'b0, 18'h0);
        check("sat_clamp", out_s, 18'h1FFFF);
        pulse(1'b0, 18'h0);
        pulse(1'b0, 18'h0);

        // Framing: five sample strobes without a symbol strobe
        pulse(1'b1, 18'h04000);
        for (int i = 1; i <= 5; i++) begin
            pulse(1'b0, 18'h0);
            check("frame_phase", 18'(phase_s), 18'(i % SPS));
            check("frame_err", 18'(sym_err_s), (i >= SPS) ? 18'h1 : 18'h0);
        end

        // Reset mid-stream, asserted between clock edges
        pulse(1'b1, 18'h0C000);
        pulse(1'b0, 18'h0);
        #2 reset = 1'b0;
        #1;
        check("midrst_out", out_s, 18'h0);
        check("midrst_phase", 18'(phase_s), 18'h0);
        check("midrst_err", 18'(sym_err_s), 18'h0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        model_reset();
        tick();
        check("midrst_hold_out", out_s, 18'h0);
        run_impulse("impulse2");

        // Symbol strobe without a sample strobe is ignored but flagged
        pulse(1'b1, 18'h10000);
        pulse(1'b0, 18'h0);
        sym_clk_en = 1'b1;
        in_s       = 18'h0ABCD;
        tick();
        sym_clk_en = 1'b0;
        model_step(1'b0, 1'b1, 18'h0ABCD);
        check("symonly_phase", 18'(phase_s), 18'h1);
        check("symonly_err", 18'(sym_err_s), 18'h1);
        check("symonly_out", out_s, last_exp);
        tick();
        pulse(1'b0, 18'h0);
        pulse(1'b0, 18'h0);
        pulse(1'b1, 18'h0);
        pulse(1'b0, 18'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
